pe_config_sequencer: RTL and testbench

//  Loads per-PE control words into a small context store, then sequences them into the PE array.

---
 rtl/pe_config_sequencer.sv | 92 +++++++++
 tb/tb_pe_config_sequencer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/pe_config_sequencer.sv
// pe_config_sequencer: loads NUM_PE*NUM_CTX ctrl words from the host, then replays
// them as contexts into the PE array, one context per RUN cycle.
module pe_config_sequencer #(
   parameter int NUM_PE  = 4,
   parameter int NUM_CTX = 4,
   parameter int CTRL_W  = 8
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     cfg_valid_i,
   input  logic [CTRL_W-1:0]        cfg_data_i,
   output logic                     cfg_ready_o,
   output logic                     cfg_done_o,
   input  logic                     cfg_reload_i,
   input  logic                     start_i,
   input  logic [7:0]               run_len_i,
   output logic                     busy_o,
   output logic                     done_o,
   output logic                     pe_en_o,
   output logic [NUM_PE*CTRL_W-1:0] pe_ctrl_o
);
   localparam int WORDS = NUM_PE * NUM_CTX;
   localparam int WPW = $clog2(WORDS);
   localparam int CPW = $clog2(NUM_CTX);
   localparam int CTX_W = NUM_PE * CTRL_W;
   localparam logic [WPW-1:0] LAST = WPW'(WORDS - 1);

   typedef enum logic [2:0] {IDLE, LOAD, LOADED, RUN, DONE} state_t;

   state_t               state_q, state_d;
   logic [WPW-1:0]       wptr_q, wptr_d;
   logic [CPW-1:0]       ctx_q, ctx_d;
   logic [7:0]           steps_q, steps_d;
   logic [WORDS*CTRL_W-1:0] store_q;
   logic [CTX_W-1:0]     hold_q;
   logic                 accept;

   assign cfg_ready_o = (state_q == IDLE) || (state_q == LOAD);
   assign cfg_done_o  = (state_q == LOADED) || (state_q == RUN) || (state_q == DONE);
   assign busy_o      = state_q == RUN;
   assign pe_en_o     = state_q == RUN;
   assign done_o      = state_q == DONE;
   assign accept      = cfg_valid_i & cfg_ready_o;
   // Context c occupies consecutive words, so PE0 lands in the low slice.
   assign pe_ctrl_o   = (state_q == RUN) ? store_q[ctx_q*CTX_W +: CTX_W] : hold_q;

   always_comb begin
      state_d = state_q;
      wptr_d  = wptr_q;
      ctx_d   = ctx_q;
      steps_d = steps_q;
      if (accept) wptr_d = (wptr_q == LAST) ? '0 : wptr_q + 1'b1;
      case (state_q)
         IDLE, LOAD: if (accept) state_d = (wptr_q == LAST) ? LOADED : LOAD;
         LOADED: begin
            if (start_i) begin
               state_d = (run_len_i != 8'd0) ? RUN : DONE;
               ctx_d   = '0;
               steps_d = run_len_i;
            end else if (cfg_reload_i) begin
               state_d = IDLE;
               wptr_d  = '0;
            end
         end
         RUN: begin
            ctx_d   = ctx_q + 1'b1;
            steps_d = steps_q - 8'd1;
            if (steps_q == 8'd1) state_d = DONE;
         end
         DONE: state_d = LOADED;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         wptr_q  <= '0;
         ctx_q   <= '0;
         steps_q <= '0;
         store_q <= '0;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         wptr_q  <= wptr_d;
         ctx_q   <= ctx_d;
         steps_q <= steps_d;
         hold_q  <= pe_ctrl_o;
         if (accept) store_q[wptr_q*CTRL_W +: CTRL_W] <= cfg_data_i;
      end
   end
endmodule

// File: tb/tb_pe_config_sequencer.sv
// tb_pe_config_sequencer: directed scenarios plus random traffic, checked every cycle
// against a word-count/step-count model of the sequencer.
module tb_pe_config_sequencer;
   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        cfg_valid_i = 1'b0;
   logic [7:0]  cfg_data_i = '0;
   logic        cfg_reload_i = 1'b0;
   logic        start_i = 1'b0;
   logic [7:0]  run_len_i = '0;
   logic        cfg_ready_o, cfg_done_o, busy_o, done_o, pe_en_o;
   logic [31:0] pe_ctrl_o;

   int checks = 0;
   int errors = 0;

   pe_config_sequencer dut (
      .clk_i(clk_i), .rst_i(rst_i), .cfg_valid_i(cfg_valid_i), .cfg_data_i(cfg_data_i),
      .cfg_ready_o(cfg_ready_o), .cfg_done_o(cfg_done_o), .cfg_reload_i(cfg_reload_i),
      .start_i(start_i), .run_len_i(run_len_i), .busy_o(busy_o), .done_o(done_o),
      .pe_en_o(pe_en_o), .pe_ctrl_o(pe_ctrl_o)
   );

   initial forever #5 clk_i = ~clk_i;

   // Model: how many words are in, whether the store is full, steps left, done pending.
   logic [7:0]  mem [16];
   int          m_loaded, m_left, m_step;
   bit          m_full, m_done;
   logic [31:0] m_last;

   function automatic logic [31:0] ctx_word(int k);
      logic [31:0] w;
      for (int p = 0; p < 4; p++) w[p*8 +: 8] = mem[k*4 + p];
      return w;
   endfunction

   always @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < 16; i++) mem[i] = '0;
         m_loaded = 0; m_left = 0; m_step = 0; m_full = 0; m_done = 0; m_last = '0;
      end else if (!m_full) begin
         if (cfg_valid_i) begin
            mem[m_loaded] = cfg_data_i;
            m_loaded++;
            if (m_loaded == 16) begin
               m_full = 1; m_loaded = 0;
            end
         end
      end else if (m_left > 0) begin
         m_last = ctx_word(m_step % 4);
         m_step++;
         m_left--;
         if (m_left == 0) m_done = 1;
      end else if (m_done) m_done = 0;
      else if (start_i) begin
         if (run_len_i == 0) m_done = 1;
         else begin
            m_left = run_len_i; m_step = 0;
         end
      end else if (cfg_reload_i) m_full = 0;
   end

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk_i) begin
      chk("cfg_ready", 32'(cfg_ready_o), 32'(!m_full));
      chk("cfg_done", 32'(cfg_done_o), 32'(m_full));
      chk("busy", 32'(busy_o), 32'(m_left > 0));
      chk("pe_en", 32'(pe_en_o), 32'(m_left > 0));
      chk("done", 32'(done_o), 32'(m_done));
      chk("pe_ctrl", pe_ctrl_o, (m_left > 0) ? ctx_word(m_step % 4) : m_last);
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_reset();
      rst_i = 1'b1; cfg_valid_i = 0; start_i = 0; cfg_reload_i = 0;
      tick(); tick();
      rst_i = 1'b0;
   endtask

   task automatic load(logic [7:0] base);
      for (int i = 0; i < 16; i++) begin
         cfg_valid_i = 1; cfg_data_i = base + 8'(i);
         tick();
      end
      cfg_valid_i = 0;
   endtask

   task automatic go(logic [7:0] len);
      start_i = 1; run_len_i = len;
      tick();
      start_i = 0;
   endtask

   initial begin
      #1;
      do_reset();
      chk("rst_ready", 32'(cfg_ready_o), 32'd1);
      chk("rst_pe_ctrl", pe_ctrl_o, 32'd0);
      // Stream load, then a 6-step run
      load(8'h10);
      chk("t1_done", 32'(cfg_done_o), 32'd1);
      chk("t1_ready", 32'(cfg_ready_o), 32'd0);
      go(8'd6);
      chk("t2_ctx0", pe_ctrl_o, 32'h13121110);
      tick();
      chk("t2_ctx1", pe_ctrl_o, 32'h17161514);
      repeat (4) tick();
      chk("t2_ctx1b", pe_ctrl_o, 32'h17161514);
      tick();
      chk("t2_done", 32'(done_o), 32'd1);
      chk("t2_pe_en", 32'(pe_en_o), 32'd0);
      tick();
      chk("t2_loaded", 32'(cfg_done_o & ~done_o), 32'd1);
      // Start ignored in IDLE, toggled-valid load, zero-length run
      do_reset();
      go(8'd5);
      chk("t4_idle", 32'(cfg_ready_o & ~busy_o), 32'd1);
      for (int i = 0; i < 31; i++) begin
         cfg_valid_i = (i % 2 == 0); cfg_data_i = 8'h10 + 8'(i / 2);
         tick();
      end
      cfg_valid_i = 0;
      chk("t3_done", 32'(cfg_done_o), 32'd1);
      chk("t4_pe_ctrl0", pe_ctrl_o, 32'd0);
      go(8'd0);
      chk("t4_done", 32'(done_o), 32'd1);
      chk("t4_pe_en", 32'(pe_en_o), 32'd0);
      tick();
      go(8'd1);
      chk("t3_ctx0", pe_ctrl_o, 32'h13121110);
      tick(); tick();
      // Reset on third RUN cycle
      go(8'd10);
      tick(); tick();
      #2 rst_i = 1'b1;
      #1;
      chk("t5_pe_en", 32'(pe_en_o), 32'd0);
      chk("t5_busy", 32'(busy_o), 32'd0);
      tick();
      rst_i = 1'b0;
      tick();
      chk("t5_ready", 32'(cfg_ready_o), 32'd1);
      chk("t5_cfg_done", 32'(cfg_done_o), 32'd0);
      // Reload path
      load(8'h50);
      cfg_reload_i = 1;
      tick();
      cfg_reload_i = 0;
      chk("t6_idle", 32'(cfg_ready_o), 32'd1);
      load(8'hA0);
      go(8'd1);
      chk("t6_ctx0", pe_ctrl_o, 32'hA3A2A1A0);
      chk("t6_pe_en", 32'(pe_en_o), 32'd1);
      tick();
      chk("t6_done", 32'(done_o), 32'd1);
      // Longest run
      tick();
      go(8'd255);
      repeat (256) tick();
      // Random traffic
      for (int c = 0; c < 4000; c++) begin
         if ($urandom_range(0, 599) == 0) do_reset();
         cfg_valid_i  = 1'($urandom);
         cfg_data_i   = 8'($urandom);
         start_i      = ($urandom_range(0, 7) == 0);
         run_len_i    = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 12));
         cfg_reload_i = ($urandom_range(0, 5) == 0);
         tick();
      end
      cfg_valid_i = 0; start_i = 0; cfg_reload_i = 0;
      tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
